// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RISC-V core.
// Decodes PC / IF-ID / ID-EX enables and flushes from load-use hazards,
// taken branches resolved in EX and multi-cycle EX operations. It also keeps
// saturating stall/flush statistics and a sticky multi-cycle timeout flag.
module pipeline_hazard_ctrl #(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_uses_rs1,
  input  logic             i_id_uses_rs2,
  input  logic             i_ex_valid,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_is_load,
  input  logic             i_ex_branch_taken,
  input  logic             i_ex_mc_start,
  input  logic             i_mc_done,
  output logic             o_pc_en,
  output logic             o_ifid_en,
  output logic             o_ifid_flush,
  output logic             o_idex_en,
  output logic             o_idex_flush,
  output logic             o_ex_hold,
  output logic             o_state,
  output logic             o_mc_timeout,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_events
);

  localparam int WC_W = (MC_TIMEOUT < 1) ? 1 : $clog2(MC_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_LIMIT = WC_W'(MC_TIMEOUT);

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MC_WAIT = 1'b1
  } state_t;

  state_t            r_state;
  logic [WC_W-1:0]   r_wait_cnt;
  logic              r_mc_timeout;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_luh;
  logic w_pc_en;
  logic w_ifid_en;
  logic w_ifid_flush;
  logic w_idex_en;
  logic w_idex_flush;
  logic w_ex_hold;
  logic w_enter_wait;
  logic w_release;
  logic w_timeout_hit;
  logic w_flush_evt;

  // x0 is never a real producer, so a load to x0 cannot create a hazard.
  assign w_luh = i_ex_valid & i_ex_is_load & (i_ex_rd != 5'd0) &
                 ((i_id_uses_rs1 & (i_id_rs1 == i_ex_rd)) |
                  (i_id_uses_rs2 & (i_id_rs2 == i_ex_rd)));

  // Mealy decode of control outputs; hazard inputs are masked while in reset.
  always_comb begin
    w_pc_en       = 1'b1;
    w_ifid_en     = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_en     = 1'b1;
    w_idex_flush  = 1'b0;
    w_ex_hold     = 1'b0;
    w_enter_wait  = 1'b0;
    w_release     = 1'b0;
    w_timeout_hit = 1'b0;
    w_flush_evt   = 1'b0;
    if (i_rst_n) begin
      case (r_state)
        ST_RUN: begin
          if (i_ex_branch_taken) begin
            // The flushed multi-cycle op (if any) is younger than the branch.
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
            w_flush_evt  = 1'b1;
          end else if (i_ex_mc_start && i_ex_valid) begin
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_en    = 1'b0;
            w_ex_hold    = 1'b1;
            w_enter_wait = 1'b1;
          end else if (w_luh) begin
            // One bubble: the load reaches MEM next cycle and can forward.
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_flush = 1'b1;
          end
        end
        ST_MC_WAIT: begin
          if (i_mc_done) begin
            w_release = 1'b1;
          end else if (r_wait_cnt >= WC_LIMIT) begin
            w_release     = 1'b1;
            w_timeout_hit = 1'b1;
          end else begin
            w_pc_en   = 1'b0;
            w_ifid_en = 1'b0;
            w_idex_en = 1'b0;
            w_ex_hold = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM, wait counter, sticky timeout and saturating statistics.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_RUN;
      r_wait_cnt   <= '0;
      r_mc_timeout <= 1'b0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_enter_wait) begin
            r_state    <= ST_MC_WAIT;
            r_wait_cnt <= WC_W'(1);
          end
        end
        ST_MC_WAIT: begin
          if (w_release) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + WC_W'(1);
          end
        end
        default: r_state <= ST_RUN;
      endcase
      if (w_timeout_hit) begin
        r_mc_timeout <= 1'b1;
      end
      if (!w_pc_en && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_flush_evt && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign o_pc_en        = w_pc_en;
  assign o_ifid_en      = w_ifid_en;
  assign o_ifid_flush   = w_ifid_flush;
  assign o_idex_en      = w_idex_en;
  assign o_idex_flush   = w_idex_flush;
  assign o_ex_hold      = w_ex_hold;
  assign o_state        = r_state;
  assign o_mc_timeout   = r_mc_timeout;
  assign o_stall_cycles = r_stall_cnt;
  assign o_flush_events = r_flush_cnt;

endmodule
